// File: rtl/fft_symbol_sequencer.sv
// Symbol sequencer around a 64-point FFT core: loads 64 samples, waits for the
// FFT done pulse, then drains bins 0..63 as a valid/ready stream. Only one symbol
// is in flight, so the FFT output bank is stable for the whole drain.
module fft_symbol_sequencer #(
  parameter int unsigned DW           = 16,
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_enable,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  output logic          fft_load_valid,
  output logic [DW-1:0] fft_load_re,
  output logic [DW-1:0] fft_load_im,
  input  logic          fft_done,
  output logic [5:0]    fft_read_addr,
  input  logic [DW-1:0] fft_read_re,
  input  logic [DW-1:0] fft_read_im,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_re,
  output logic [DW-1:0] m_im,
  output logic [5:0]    m_index,
  output logic          m_last,
  output logic          o_busy,
  output logic          o_err_timeout,
  output logic          o_err_spurious,
  output logic [15:0]   o_sym_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDrain} state_e;

  localparam logic [9:0] TimeoutCnt = 10'(DONE_TIMEOUT);

  state_e        state_q, state_d;
  logic [6:0]    load_cnt_q, load_cnt_d;
  logic [9:0]    wait_cnt_q, wait_cnt_d;
  logic [5:0]    rd_addr_q, rd_addr_d;
  logic [6:0]    fetch_cnt_q, fetch_cnt_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_re_q, m_re_d;
  logic [DW-1:0] m_im_q, m_im_d;
  logic [5:0]    m_index_q, m_index_d;
  logic          m_last_q, m_last_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_spurious_q, err_spurious_d;
  logic [15:0]   sym_count_q, sym_count_d;
  logic          out_hs;

  // Load port is a zero-latency passthrough gated by the LOAD state.
  always_comb begin
    s_ready        = (state_q == StLoad);
    fft_load_valid = s_valid & s_ready;
    fft_load_re    = s_re;
    fft_load_im    = s_im;
    fft_read_addr  = rd_addr_q;
    m_valid        = m_valid_q;
    m_re           = m_re_q;
    m_im           = m_im_q;
    m_index        = m_index_q;
    m_last         = m_last_q;
    o_busy         = (state_q != StIdle);
    o_err_timeout  = err_timeout_q;
    o_err_spurious = err_spurious_q;
    o_sym_count    = sym_count_q;
  end

  // Next-state, counters and the one-entry output register.
  always_comb begin
    state_d        = state_q;
    load_cnt_d     = load_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    rd_addr_d      = rd_addr_q;
    fetch_cnt_d    = fetch_cnt_q;
    m_valid_d      = m_valid_q;
    m_re_d         = m_re_q;
    m_im_d         = m_im_q;
    m_index_d      = m_index_q;
    m_last_d       = m_last_q;
    err_timeout_d  = err_timeout_q;
    err_spurious_d = err_spurious_q;
    sym_count_d    = sym_count_q;
    out_hs         = m_valid_q & m_ready;

    // A done pulse outside WAIT never steers control, only flags.
    if (fft_done && (state_q != StWait)) err_spurious_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (i_enable) state_d = StLoad;
      end
      StLoad: begin
        if (fft_load_valid) begin
          if (load_cnt_q == 7'd63) begin
            load_cnt_d = '0;
            state_d    = StWait;
          end else begin
            load_cnt_d = load_cnt_q + 7'd1;
          end
        end
      end
      StWait: begin
        // Done takes priority over a timeout landing on the same cycle.
        if (fft_done) begin
          wait_cnt_d = '0;
          state_d    = StDrain;
        end else if (wait_cnt_q == TimeoutCnt) begin
          wait_cnt_d    = '0;
          err_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 10'd1;
        end
      end
      StDrain: begin
        if (out_hs && m_last_q) begin
          m_valid_d   = 1'b0;
          fetch_cnt_d = '0;
          sym_count_d = sym_count_q + 16'd1;
          state_d     = StIdle;
        end else if ((!m_valid_q || out_hs) && (fetch_cnt_q < 7'd64)) begin
          m_re_d      = fft_read_re;
          m_im_d      = fft_read_im;
          m_index_d   = rd_addr_q;
          m_last_d    = (rd_addr_q == 6'd63);
          m_valid_d   = 1'b1;
          rd_addr_d   = rd_addr_q + 6'd1;
          fetch_cnt_d = fetch_cnt_q + 7'd1;
        end else if (out_hs) begin
          m_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      load_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      rd_addr_q      <= '0;
      fetch_cnt_q    <= '0;
      m_valid_q      <= 1'b0;
      m_re_q         <= '0;
      m_im_q         <= '0;
      m_index_q      <= '0;
      m_last_q       <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
      sym_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      rd_addr_q      <= rd_addr_d;
      fetch_cnt_q    <= fetch_cnt_d;
      m_valid_q      <= m_valid_d;
      m_re_q         <= m_re_d;
      m_im_q         <= m_im_d;
      m_index_q      <= m_index_d;
      m_last_q       <= m_last_d;
      err_timeout_q  <= err_timeout_d;
      err_spurious_q <= err_spurious_d;
      sym_count_q    <= sym_count_d;
    end
  end

endmodule

// File: tb/tb_fft_symbol_sequencer.sv
// Directed bench for fft_symbol_sequencer with a behavioural 64-point DFT standing
// in for the FFT core (done pulse a programmable number of cycles after load).
module tb_fft_symbol_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_re = '0;
  logic [15:0] s_im = '0;
  logic        fft_load_valid;
  logic [15:0] fft_load_re, fft_load_im;
  logic        fft_done;
  logic [5:0]  fft_read_addr;
  logic [15:0] fft_read_re, fft_read_im;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_re, m_im;
  logic [5:0]  m_index;
  logic        m_last, o_busy, o_err_timeout, o_err_spurious;
  logic [15:0] o_sym_count;

  fft_symbol_sequencer #(.DW(16), .DONE_TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .fft_load_valid(fft_load_valid), .fft_load_re(fft_load_re), .fft_load_im(fft_load_im),
    .fft_done(fft_done), .fft_read_addr(fft_read_addr),
    .fft_read_re(fft_read_re), .fft_read_im(fft_read_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_index(m_index), .m_last(m_last), .o_busy(o_busy),
    .o_err_timeout(o_err_timeout), .o_err_spurious(o_err_spurious),
    .o_sym_count(o_sym_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FFT core model ----------------
  logic        fake_done = 1'b0;
  logic        spur_done = 1'b0;
  assign fft_done = fake_done | spur_done;

  logic signed [15:0] bank_re [64];
  logic signed [15:0] bank_im [64];
  assign fft_read_re = bank_re[fft_read_addr];
  assign fft_read_im = bank_im[fft_read_addr];

  int ld_re [64];
  int ld_im [64];
  int ld_idx = 0;
  int pend = 0;
  int done_cyc = 0;
  int done_delay = 2;
  bit suppress = 1'b0;

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  task automatic compute_bank();
    for (int k = 0; k < 64; k++) begin
      real acc_re, acc_im, th;
      acc_re = 0.0;
      acc_im = 0.0;
      for (int n = 0; n < 64; n++) begin
        th = 2.0 * 3.14159265358979 * real'(k * n) / 64.0;
        acc_re = acc_re + real'(ld_re[n]) * $cos(th) + real'(ld_im[n]) * $sin(th);
        acc_im = acc_im + real'(ld_im[n]) * $cos(th) - real'(ld_re[n]) * $sin(th);
      end
      bank_re[k] = 16'(rnd(acc_re));
      bank_im[k] = 16'(rnd(acc_im));
    end
  endtask

  // Sampled on the falling edge: inputs are stable and equal what the DUT sees next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ld_idx    = 0;
      pend      = 0;
      fake_done = 1'b0;
    end else begin
      fake_done = (pend == 1);
      if (pend == 1) done_cyc = cyc;
      if (pend > 0) pend--;
      if (fft_load_valid) begin
        ld_re[ld_idx] = int'($signed(fft_load_re));
        ld_im[ld_idx] = int'($signed(fft_load_im));
        if (ld_idx == 63) begin
          compute_bank();
          ld_idx = 0;
          if (!suppress) pend = done_delay;
        end else begin
          ld_idx++;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [15:0] obs, input int exp);
    int d;
    d = int'(obs) - exp;
    n_cmp++;
    assert (!$isunknown(obs) && d >= -1 && d <= 1) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (+-1)", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_re"}, m_re, 0);
    check({tag, "_m_im"}, m_im, 0);
    check({tag, "_m_index"}, m_index, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_rd_addr"}, fft_read_addr, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_load_valid"}, fft_load_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_err_to"}, o_err_timeout, 0);
    check({tag, "_err_sp"}, o_err_spurious, 0);
    check({tag, "_sym_count"}, o_sym_count, 0);
  endtask

  int in_re [64];
  int start_cyc, first_rdy_cyc, last_load_cyc, first_v_cyc, last_hs_cyc, lh, c0;

  task automatic set_impulse(input int pos, input int amp);
    for (int i = 0; i < 64; i++) in_re[i] = 0;
    in_re[pos] = amp;
  endtask

  task automatic send_symbol(input bit keep_en, input int spur_at);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < 64 && guard < 500) begin
      @(posedge clk); #1;
      i_enable  = (i == 0) || keep_en;
      s_valid   = 1'b1;
      s_re      = 16'(in_re[i]);
      s_im      = '0;
      spur_done = (i == spur_at);
      @(negedge clk);
      if (guard == 0) start_cyc = cyc;
      if (s_ready) begin
        if (i == 0) first_rdy_cyc = cyc;
        if (i == 0 || i == 63) begin
          check("load_valid", fft_load_valid, 1);
          check("load_re", $signed(fft_load_re), in_re[i]);
        end
        i++;
      end
      guard++;
    end
    check("load_count", i, 64);
    last_load_cyc = cyc;
    @(posedge clk); #1;
    s_valid   = keep_en;
    spur_done = 1'b0;
    if (!keep_en) i_enable = 1'b0;
  endtask

  task automatic receive_symbol(input int mode, input int amp, input bit bp, input int abort_at);
    int k, n, guard, exp_re, exp_im;
    bit held, got_first, chk;
    logic [15:0] h_re, h_im;
    logic [5:0]  h_idx;
    k = 0; n = 0; guard = 0; held = 0; got_first = 0;
    while (k < 64 && guard < 1000) begin
      @(posedge clk); #1;
      m_ready = bp ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      n++;
      guard++;
      @(negedge clk);
      if (held) begin
        check("stall_valid", m_valid, 1);
        check("stall_re", $signed(m_re), $signed(h_re));
        check("stall_im", $signed(m_im), $signed(h_im));
        check("stall_index", m_index, h_idx);
      end
      if (m_valid && !got_first) begin
        got_first   = 1;
        first_v_cyc = cyc;
      end
      if (m_valid && abort_at == k) return;
      if (m_valid && m_ready) begin
        check("bin_index", m_index, k);
        check("bin_last", m_last, (k == 63));
        check("drain_s_ready", s_ready, 0);
        check("drain_load_valid", fft_load_valid, 0);
        chk = 1; exp_re = 0; exp_im = 0;
        case (mode)
          0: exp_re = amp;
          1: exp_re = (k == 0) ? 16384 : 0;
          default: begin
            chk = (k % 16 == 0);
            if (k == 0)  exp_re = 1024;
            if (k == 16) exp_im = -1024;
            if (k == 32) exp_re = -1024;
            if (k == 48) exp_im = 1024;
          end
        endcase
        if (chk) begin
          check_near("bin_re", m_re, exp_re);
          check_near("bin_im", m_im, exp_im);
        end
        k++;
        if (k == 64) last_hs_cyc = cyc;
      end
      held = m_valid && !m_ready;
      h_re = m_re; h_im = m_im; h_idx = m_index;
    end
    check("drain_bins", k, 64);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Impulse (1024,0) at n=0: every bin 1024
    set_impulse(0, 1024);
    send_symbol(1'b0, -1);
    check("idle_to_load", first_rdy_cyc - start_cyc, 1);
    receive_symbol(0, 1024, 1'b0, -1);
    check("done_to_valid", first_v_cyc - done_cyc, 2);
    check("bin_burst_len", last_hs_cyc - first_v_cyc, 63);
    @(negedge clk);
    check("imp_busy", o_busy, 0);
    check("imp_m_valid", m_valid, 0);
    check("imp_sym_count", o_sym_count, 1);

    // DC 64x(256,0) under 1-0-0-1 backpressure
    for (int i = 0; i < 64; i++) in_re[i] = 256;
    send_symbol(1'b0, -1);
    receive_symbol(1, 0, 1'b1, -1);
    @(negedge clk);
    check("dc_sym_count", o_sym_count, 2);

    // Back-to-back: three symbols, enable and valid held high
    set_impulse(0, 100);
    send_symbol(1'b1, -1);
    receive_symbol(0, 100, 1'b0, -1);
    lh = last_hs_cyc;
    set_impulse(0, 200);
    send_symbol(1'b1, -1);
    check("b2b_gap1", first_rdy_cyc - lh, 2);
    receive_symbol(0, 200, 1'b0, -1);
    lh = last_hs_cyc;
    set_impulse(0, 300);
    send_symbol(1'b0, -1);
    check("b2b_gap2", first_rdy_cyc - lh, 2);
    receive_symbol(0, 300, 1'b0, -1);
    @(negedge clk);
    check("b2b_sym_count", o_sym_count, 5);

    // Done on the very cycle the timeout would fire: done wins
    done_delay = 11;
    set_impulse(0, 700);
    send_symbol(1'b0, -1);
    receive_symbol(0, 700, 1'b0, -1);
    check("late_done_to_valid", first_v_cyc - done_cyc, 2);
    @(negedge clk);
    check("late_err_to", o_err_timeout, 0);
    check("late_sym_count", o_sym_count, 6);
    done_delay = 2;

    // Timeout: done never arrives
    suppress = 1'b1;
    set_impulse(0, 900);
    send_symbol(1'b0, -1);
    c0 = last_load_cyc;
    repeat (11) @(negedge clk);
    check("to_cycle", cyc - c0, 11);
    check("to_before_err", o_err_timeout, 0);
    check("to_before_busy", o_busy, 1);
    @(negedge clk);
    check("to_err", o_err_timeout, 1);
    check("to_busy", o_busy, 0);
    check("to_m_valid", m_valid, 0);
    check("to_sym_count", o_sym_count, 6);
    suppress = 1'b0;

    // Spurious done during LOAD at load_cnt=20; impulse at n=1
    check("sp_before", o_err_spurious, 0);
    set_impulse(1, 1024);
    send_symbol(1'b0, 20);
    check("sp_err", o_err_spurious, 1);
    receive_symbol(2, 0, 1'b0, -1);
    @(negedge clk);
    check("sp_sym_count", o_sym_count, 7);
    check("sp_err_to_sticky", o_err_timeout, 1);

    // Reset while bin 30 is presented, then a clean symbol
    set_impulse(0, 1024);
    send_symbol(1'b0, -1);
    receive_symbol(0, 1024, 1'b0, 30);
    check("abort_index", m_index, 30);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_impulse(0, 500);
    send_symbol(1'b0, -1);
    receive_symbol(0, 500, 1'b0, -1);
    @(negedge clk);
    check("post_rst_sym_count", o_sym_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_symbol_sequencer.md
# fft_symbol_sequencer

Sequences the 64-point FFT core for streaming OFDM symbols. Accepts a valid/ready sample stream, feeds exactly 64 samples per symbol into the FFT load port, waits for the FFT done pulse, then sweeps the FFT read address 0..63 and emits the bins as a valid/ready output stream with last/index sidebands. One symbol is in flight at a time, so the FFT's published bank never changes while it is being drained, regardless of output backpressure.

## Interface
- DW, 16, sample/bin component width (signed)
- DONE_TIMEOUT, 255, max cycles in WAIT before abandoning a symbol (1..1023)
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  permits starting a new symbol; sampled only at symbol boundary
- s_valid / s_ready  in / out  1 / 1  input sample handshake
- s_re, s_im  in  DW each  input sample
- fft_load_valid  out  1  to FFT i_load_valid
- fft_load_re, fft_load_im  out  DW each  to FFT i_load_re/im
- fft_done  in  1  FFT o_done pulse
- fft_read_addr  out  6  to FFT i_read_addr
- fft_read_re, fft_read_im  in  DW each  FFT read data, combinational from fft_read_addr
- m_valid / m_ready  out / in  1 / 1  output bin handshake
- m_re, m_im  out  DW each  bin value
- m_index  out  6  bin number of current output
- m_last  out  1  high with bin 63
- o_busy  out  1  high whenever state != IDLE
- o_err_timeout  out  1  sticky; set on WAIT timeout
- o_err_spurious  out  1  sticky; fft_done seen outside WAIT
- o_sym_count  out  16  completed symbols, wraps 0xFFFF→0

## Operation
- States: IDLE, LOAD, WAIT, DRAIN.
- IDLE: s_ready=0. Go to LOAD when i_enable=1.
- LOAD: s_ready=1. fft_load_valid = s_valid & s_ready (combinational); fft_load_re/im = s_re/s_im passthrough. 7-bit load_cnt counts handshakes; on the 64th (load_cnt==63) go WAIT, load_cnt←0. i_enable ignored mid-symbol.
- WAIT: s_ready=0, fft_load_valid=0. wait_cnt increments each cycle. fft_done=1 → DRAIN, wait_cnt←0. wait_cnt==DONE_TIMEOUT without done → set o_err_timeout, go IDLE (symbol dropped, no output).
- DRAIN: rd_addr (6-bit register) drives fft_read_addr. One-entry output register: when empty, or m_valid&m_ready this cycle, and fewer than 64 bins fetched, capture m_re/m_im←fft_read_re/im, m_index←rd_addr, m_last←(rd_addr==63), m_valid←1, rd_addr←rd_addr+1 (wraps to 0 after 63). Handshake on m_last: m_valid←0, o_sym_count+1, go IDLE (i_enable=1 → LOAD next cycle via IDLE).
- Output data is held stable while m_valid=1 and m_ready=0.
- fft_done in IDLE, LOAD or DRAIN: ignored for control, sets o_err_spurious.
- Sticky errors cleared only by reset.
- Reset (any time, including mid-LOAD or mid-DRAIN): state IDLE, all counters 0, m_valid=0, m_re/m_im/m_index=0, m_last=0, fft_read_addr=0, s_ready=0, fft_load_valid=0, o_busy=0, both errors 0, o_sym_count=0. Partial symbols are discarded; FFT shares rst_n.

## Timing
- IDLE→LOAD: 1 cycle after i_enable sampled high; s_ready rises that cycle.
- Load latency 0: accepted sample appears on FFT load port same cycle.
- FFT done arrives 2 cycles after 64th load handshake; WAIT must tolerate any delay ≤ DONE_TIMEOUT.
- fft_done at cycle T → DRAIN at T+1, first m_valid (bin 0) at T+2.
- With m_ready held 1: bins on 64 consecutive cycles T+2..T+65, m_last at T+65, IDLE at T+66, LOAD at T+67 if i_enable=1.
- Backpressure: unlimited stall allowed; FFT output bank is stable because no new load occurs until DRAIN ends.
- Simultaneous fft_done and WAIT timeout on same cycle: done wins, no error.

## Test plan
- Impulse: i_enable=1, samples (1024,0) then 63×(0,0), m_ready=1 → 64 bins each re=1024, im=0 (±1 LSB), m_index 0..63, m_last only on bin 63, o_sym_count=1.
- Backpressure: DC input 64×(256,0), m_ready toggling 1-0-0-1 → bin 0 = (16384,0), bins 1..63 ≈0; m_re/m_index stable during stalls, no bins lost/duplicated, s_ready=0 throughout DRAIN.
- Back-to-back: 3 symbols with i_enable=1 and s_valid=1 continuously → 192 loads, 192 bins, o_sym_count=3, each symbol's LOAD starts exactly 2 cycles after prior m_last handshake.
- Timeout: DONE_TIMEOUT=10, FFT done forced low → o_err_timeout=1 at WAIT cycle 10, state IDLE, no m_valid, o_sym_count unchanged.
- Spurious done: pulse fft_done during LOAD at load_cnt=20 → o_err_spurious=1, load continues to 64, normal output follows.
- Reset mid-DRAIN at bin 30 → all outputs at reset values next cycle; new symbol afterward completes correctly with m_index starting at 0.
